// File: rtl/iod_delay_tap_ctrl.sv
// Lane-addressed tap command sequencer for the RX IOD delay lines.
// Emits DIR/MOVE/LOAD pulses per lane and keeps a shadow tap per lane.
module iod_delay_tap_ctrl #(
   parameter int NUM_LANES   = 4,
   parameter int LANE_W      = 2,
   parameter int TAP_W       = 8,
   parameter int MAX_TAP     = 255,
   parameter int DEFAULT_TAP = 1,
   parameter int MOVE_GAP    = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [1:0]                 cmd_op,
   input  logic [LANE_W-1:0]          cmd_lane,
   input  logic [TAP_W-1:0]           cmd_val,
   output logic [NUM_LANES-1:0]       delay_line_dir,
   output logic [NUM_LANES-1:0]       delay_line_move,
   output logic [NUM_LANES-1:0]       delay_line_load,
   input  logic [NUM_LANES-1:0]       delay_line_out_of_range,
   output logic [NUM_LANES*TAP_W-1:0] tap_value,
   output logic                       done,
   output logic                       err
);

   localparam int GW = (MOVE_GAP > 1) ? $clog2(MOVE_GAP + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_MOVE, S_GAP, S_LOADP, S_FIN
   } state_t;

   state_t              state, state_n;
   logic [LANE_W-1:0]   lane_q;
   logic                up_q, up_d;
   logic [TAP_W-1:0]    steps_q, steps_d;
   logic [GW-1:0]       gap_q;
   logic                err_q, err_d, set_err, ld;
   logic [TAP_W-1:0]    taps [NUM_LANES];
   logic [NUM_LANES-1:0] oor_s1, oor_s2;

   logic                lane_ok, over, sat;
   logic [TAP_W-1:0]    cur, tgt;

   assign lane_ok = {1'b0, cmd_lane} < (LANE_W+1)'(NUM_LANES);
   assign cur     = lane_ok ? taps[cmd_lane] : '0;
   assign over    = {1'b0, cmd_val} > (TAP_W+1)'(MAX_TAP);
   assign tgt     = over ? TAP_W'(MAX_TAP) : cmd_val;
   // Saturation is judged before each step against the live shadow tap
   assign sat     = up_q ? (taps[lane_q] == TAP_W'(MAX_TAP))
                         : (taps[lane_q] == '0);

   always_comb begin
      state_n = state;
      ld      = 1'b0;
      up_d    = 1'b0;
      steps_d = '0;
      err_d   = 1'b0;
      set_err = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (cmd_valid) begin
               ld = 1'b1;
               if (!lane_ok) begin
                  err_d   = 1'b1;
                  state_n = S_FIN;
               end else begin
                  unique case (cmd_op)
                     2'b00: state_n = S_LOADP;
                     2'b01: begin
                        up_d    = 1'b1;
                        steps_d = cmd_val;
                     end
                     2'b10: steps_d = cmd_val;
                     2'b11: begin
                        up_d    = tgt > cur;
                        steps_d = up_d ? tgt - cur : cur - tgt;
                        err_d   = over;
                     end
                  endcase
                  if (cmd_op != 2'b00)
                     state_n = (steps_d == '0) ? S_FIN : S_SETUP;
               end
            end
         end
         S_SETUP: begin
            set_err = sat;
            state_n = sat ? S_FIN : S_MOVE;
         end
         S_MOVE: state_n = S_GAP;
         S_GAP: begin
            if (gap_q == '0) begin
               if (oor_s2[lane_q]) begin
                  set_err = 1'b1;
                  state_n = S_FIN;
               end else if (steps_q == '0) begin
                  state_n = S_FIN;
               end else if (sat) begin
                  set_err = 1'b1;
                  state_n = S_FIN;
               end else begin
                  state_n = S_MOVE;
               end
            end
         end
         S_LOADP: state_n = S_FIN;
         S_FIN:   state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         lane_q  <= '0;
         up_q    <= 1'b0;
         steps_q <= '0;
         gap_q   <= '0;
         err_q   <= 1'b0;
         oor_s1  <= '0;
         oor_s2  <= '0;
         for (int k = 0; k < NUM_LANES; k++)
            taps[k] <= TAP_W'(DEFAULT_TAP);
      end else begin
         state  <= state_n;
         oor_s1 <= delay_line_out_of_range;
         oor_s2 <= oor_s1;
         if (ld) begin
            lane_q  <= cmd_lane;
            up_q    <= up_d;
            steps_q <= steps_d;
            err_q   <= err_d;
         end
         if (set_err)
            err_q <= 1'b1;
         if (state == S_MOVE) begin
            taps[lane_q] <= up_q ? taps[lane_q] + 1'b1
                                 : taps[lane_q] - 1'b1;
            steps_q      <= steps_q - 1'b1;
            gap_q        <= GW'(MOVE_GAP - 1);
         end
         if (state == S_GAP && gap_q != '0)
            gap_q <= gap_q - 1'b1;
         if (state == S_LOADP)
            taps[lane_q] <= TAP_W'(DEFAULT_TAP);
      end
   end

   // Outputs decode registered state only; no input reaches them directly
   always_comb begin
      delay_line_dir  = '0;
      delay_line_move = '0;
      delay_line_load = '0;
      tap_value       = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         tap_value[k*TAP_W +: TAP_W] = taps[k];
         if (lane_q == LANE_W'(k)) begin
            delay_line_dir[k]  = up_q && (state == S_SETUP ||
                                 state == S_MOVE || state == S_GAP);
            delay_line_move[k] = (state == S_MOVE);
            delay_line_load[k] = (state == S_LOADP);
         end
      end
   end

   assign cmd_ready = (state == S_IDLE);
   assign done      = (state == S_FIN);
   assign err       = (state == S_FIN) && err_q;

endmodule

// File: doc/iod_delay_tap_ctrl.md
Name: iod_delay_tap_ctrl

Overview:
- Multi-lane controller for the RX clock-divider/IOD delay lines.
- Takes lane-addressed tap commands over a valid/ready interface and converts them into properly sequenced DELAY_LINE_DIR/MOVE/LOAD pulses per lane.
- Keeps a shadow tap count per lane and enforces saturation and out-of-range aborts.
- Sits between the RX training logic and the per-lane clock-divider/delay primitives.

Parameters:
- NUM_LANES, 4: number of delay lines controlled.
- LANE_W, 2: width of the lane select; must satisfy 2^LANE_W >= NUM_LANES.
- TAP_W, 8: width of tap counts and command values.
- MAX_TAP, 255: highest legal tap; must be <= 2^TAP_W-1.
- DEFAULT_TAP, 1: tap value restored by LOAD and by reset.
- MOVE_GAP, 4: settle cycles after each MOVE pulse; must be >= 1.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset, asynchronous assert, active-low.
- CMD_VALID  in  1  command valid.
- CMD_READY  out  1  high only in IDLE.
- CMD_OP  in  2  00 LOAD, 01 INC, 10 DEC, 11 SET_ABS.
- CMD_LANE  in  LANE_W  target lane.
- CMD_VAL  in  TAP_W  step count for INC/DEC; target tap for SET_ABS; ignored for LOAD.
- DELAY_LINE_DIR  out  NUM_LANES  per-lane direction; 1 = increase delay.
- DELAY_LINE_MOVE  out  NUM_LANES  per-lane one-cycle step pulse.
- DELAY_LINE_LOAD  out  NUM_LANES  per-lane one-cycle reload pulse.
- DELAY_LINE_OUT_OF_RANGE  in  NUM_LANES  per-lane range flag from the primitive; asynchronous.
- TAP_VALUE  out  NUM_LANES*TAP_W  shadow taps; lane k occupies bits [k*TAP_W +: TAP_W].
- DONE  out  1  one-cycle pulse when a command completes.
- ERR  out  1  one-cycle pulse coincident with DONE when the command was clipped or aborted.

Behaviour:
- Reset:
  - All DIR, MOVE, LOAD, DONE and ERR go to 0.
  - CMD_READY goes to 1 and the FSM enters IDLE.
  - Every TAP_VALUE lane goes to DEFAULT_TAP.
  - Reset mid-command abandons the command with no DONE.
- OUT_OF_RANGE is synchronised per lane with 2 flops before use.
- Handshake:
  - A command is accepted on the cycle CMD_VALID & CMD_READY; cycle 0 below is the accept cycle.
  - Op, lane and value are latched. CMD_READY goes low from cycle 1 until the cycle after DONE.
- FSM states: IDLE, SETUP, MOVE, GAP, LOADP, FIN.
- LOAD:
  - IDLE -> LOADP (cycle 1): LOAD[lane]=1 for exactly 1 cycle, TAP_VALUE[lane] := DEFAULT_TAP.
  - Then FIN (cycle 2): DONE=1.
- INC/DEC with n = CMD_VAL:
  - n = 0: go straight to FIN at cycle 1; no pulses, no ERR.
  - Otherwise IDLE -> SETUP (cycle 1): drive DIR[lane] (1 for INC, 0 for DEC). DIR holds from SETUP through the end of the last GAP.
  - MOVE: MOVE[lane]=1 for 1 cycle, shadow tap ±1.
  - GAP: MOVE_GAP cycles. Then back to MOVE if steps remain, else FIN.
  - No abort: DONE lands at cycle 2 + n*(1+MOVE_GAP).
- Saturation:
  - Before each MOVE, if the tap is already MAX_TAP (INC) or 0 (DEC), no pulse is issued.
  - The command goes to FIN with ERR=1; remaining steps are discarded.
- Out of range:
  - If the synchronised OUT_OF_RANGE[lane] is 1 on the last GAP cycle of any step, the command goes to FIN with ERR=1 after that step.
  - The shadow tap keeps the step already taken.
- SET_ABS:
  - target := min(CMD_VAL, MAX_TAP); ERR is flagged at FIN if clamped.
  - Executes as INC of (target - tap) or DEC of (tap - target). Equal: FIN at cycle 1, no pulses.
  - Step count is computed at accept time against the shadow tap.
- Invalid lane (CMD_LANE >= NUM_LANES): FIN at cycle 1 with DONE=1, ERR=1; no outputs toggle, no shadow change.
- Lane isolation: only the addressed lane's DIR/MOVE/LOAD bits may ever be nonzero. Non-addressed DIR bits hold 0.
- MOVE and LOAD are never high in the same cycle.
- FIN lasts 1 cycle then returns to IDLE. Back-to-back commands are accepted the cycle after FIN.
- All outputs are registered; no combinational path from input to output.

Test Plan:
1. Reset release, NUM_LANES=4, DEFAULT_TAP=1 -> all TAP_VALUE lanes = 1, CMD_READY=1, DIR/MOVE/LOAD = 0.
2. INC lane 2 by 3, MOVE_GAP=4 -> three MOVE[2] pulses 5 cycles apart, first at cycle 2; DIR[2]=1 throughout; DONE at cycle 17; TAP_VALUE[2]=4; ERR=0.
3. SET_ABS lane 0 to 254 from 1, then INC by 5 with MAX_TAP=255:
   - SET_ABS -> 253 MOVE pulses.
   - INC -> exactly 1 pulse, tap=255, DONE with ERR=1.
4. DEC lane 1 by 10 with OUT_OF_RANGE[1] asserted after the 2nd MOVE -> aborts after the step in progress; tap = 1 − (steps taken) clamped at 0; ERR=1. Also check DEC from 0 -> 0 pulses, ERR=1.
5. LOAD lane 3 after INC by 6 -> single LOAD[3] pulse at cycle 1, TAP_VALUE[3]=1, DONE at cycle 2. Also CMD_LANE=3 with NUM_LANES=3 -> DONE+ERR at cycle 1, no pulses.
6. RST_N asserted mid-INC (during GAP) -> MOVE/DIR clear immediately, no DONE, taps return to DEFAULT_TAP. A new command is accepted right after release.
